mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle MIPS datapath's memory port. Accepts read/write
//  requests on memAddr/writeMemData, inserts a programmable number of wait states and returns
//  read data on memData with a one-cycle memReady strobe. Holds a word-organised RAM shared
//  by instruction fetch and load/store.
// PARAMETERS
//  DEPTH_LOG2   10  log2 of word count (1024 x 32b); legal range 2..14
//  WAIT_STATES  2   extra cycles between acceptance and access; legal range 0..15
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  memRead       in   1   read request
//  memWrite      in   1   write request
//  memAddr       in   16  byte address; word index = memAddr[DEPTH_LOG2+1:2]
//  writeMemData  in   32  write data
//  memData       out  32  read data, registered, held until next read completes
//  memReady      out  1   one-cycle strobe: access complete
//  memError      out  1   one-cycle strobe with memReady: request rejected
//  busy          out  1   high in any state except IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, memData=0, memReady=0, memError=0, busy=0, counter=0.
//    RAM contents are not reset. Reset mid-request aborts it; a pending write is not committed.
//  - FSM IDLE -> WAIT -> ACCESS -> IDLE. WAIT is skipped when WAIT_STATES=0.
//  - IDLE: if memRead|memWrite, latch op, memAddr, writeMemData; counter=WAIT_STATES; go WAIT
//    (or ACCESS). Requests are sampled only in IDLE; inputs are ignored while busy.
//  - WAIT: counter decrements each cycle; go ACCESS when counter==1.
//  - ACCESS: perform access on latched values; memReady=1 for this one cycle; return to IDLE.
//    Read: memData <= RAM[idx], visible in the same cycle memReady is high.
//    Write: RAM[idx] <= latched data; memData unchanged.
//  - Latency: request sampled at edge N -> memReady high during cycle N+WAIT_STATES+1.
//  - Back-to-back: a request still asserted when IDLE is re-entered is accepted as new;
//    the requester must drop it in the memReady cycle to avoid a repeat access.
//  - Requests dropped during WAIT are still completed (request is latched).
//  - Error cases (memError=1 with memReady, no RAM write, memData unchanged):
//    memRead&memWrite together; memAddr[15:DEPTH_LOG2+2] != 0 (out of range).
//  - Addresses wrap nowhere: out-of-range is always an error, never aliased.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: memAddr[1:0]!=0 is an error (memError, no access).
//  Undefined: memAddr[1:0] ignored; access uses the containing word.
// TESTING (WAIT_STATES=2, DEPTH_LOG2=10 unless noted)
//  Write 0xDEADBEEF @0x0010, then read @0x0010 -> write memReady 3 cycles after accept; read
//    memData=0xDEADBEEF with memReady 3 cycles after accept, memError=0.
//  Read @0x1000 (out of range) -> memReady=1, memError=1, memData keeps previous value.
//  memRead=memWrite=1 @0x0020 -> memError=1; later read @0x0020 returns prior contents.
//  Assert reset during WAIT of write 0x12345678 @0x0030 -> outputs 0 immediately; a
//    subsequent read @0x0030 does not return 0x12345678.
//  WAIT_STATES=0: read held 2 cycles -> memReady in cycle after each accept, two accesses.
//  With MEM_ALIGN_CHECK_EN: read @0x0012 -> memError=1; without it: returns word @0x0010.

Source files
------------

// File: rtl/mem_responder.sv
// Word-organised RAM responder: request latched in IDLE, WAIT_STATES wait cycles, then a one-cycle memReady/memError strobe.
// Optional MEM_ALIGN_CHECK_EN rejects addresses with memAddr[1:0]!=0; inputs are ignored while busy.
module mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [15:0] memAddr,
  input  logic [31:0] writeMemData,
  output logic [31:0] memData,
  output logic        memReady,
  output logic        memError,
  output logic        busy
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t      state, nextState;
  logic        latRead, latWrite;
  logic [15:0] latAddr;
  logic [31:0] latData;
  logic [3:0]  counter;
  logic [31:0] ram [WORDS];

  logic                  accRead, accWrite, accErr, doAccess;
  logic [15:0]           accAddr;
  logic [DEPTH_LOG2-1:0] accIdx;

  // With zero wait states the access happens on the accept edge, so the live inputs are used there.
  always_comb begin
    accRead  = latRead;
    accWrite = latWrite;
    accAddr  = latAddr;
    if (state == S_IDLE) begin
      accRead  = memRead;
      accWrite = memWrite;
      accAddr  = memAddr;
    end
    accIdx = accAddr[DEPTH_LOG2+1:2];
    accErr = (accRead && accWrite) || ((32'(accAddr) >> (DEPTH_LOG2 + 2)) != 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    if (accAddr[1:0] != 2'b00) accErr = 1'b1;
`endif
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:   if (memRead || memWrite) nextState = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (counter == 4'd1) nextState = S_ACCESS;
      S_ACCESS: nextState = S_IDLE;
      default:  nextState = S_IDLE;
    endcase
  end

  assign doAccess = (nextState == S_ACCESS);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nextState;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memData  <= 32'd0;
      memReady <= 1'b0;
      memError <= 1'b0;
      counter  <= 4'd0;
      latRead  <= 1'b0;
      latWrite <= 1'b0;
      latAddr  <= 16'd0;
      latData  <= 32'd0;
    end else begin
      memReady <= doAccess;
      memError <= doAccess && accErr;
      if (doAccess && accRead && !accErr) memData <= ram[accIdx];
      if (state == S_IDLE && (memRead || memWrite)) begin
        latRead  <= memRead;
        latWrite <= memWrite;
        latAddr  <= memAddr;
        latData  <= writeMemData;
        counter  <= 4'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        counter <= counter - 4'd1;
      end
    end
  end

  // Writes commit at the end of the ACCESS cycle; a reset before then leaves the RAM untouched.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && latWrite && !memError)
      ram[latAddr[DEPTH_LOG2+1:2]] <= latData;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder (WAIT_STATES=2) plus a zero-wait-state instance.
module tb_mem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead, memWrite;
  logic [15:0] memAddr;
  logic [31:0] writeMemData;
  logic [31:0] memData;
  logic        memReady, memError, busy;

  logic        r0, w0;
  logic [15:0] a0;
  logic [31:0] d0;
  logic [31:0] memData0;
  logic        memReady0, memError0, busy0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .memAddr(memAddr), .writeMemData(writeMemData), .memData(memData),
    .memReady(memReady), .memError(memError), .busy(busy)
  );

  mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .memRead(r0), .memWrite(w0),
    .memAddr(a0), .writeMemData(d0), .memData(memData0),
    .memReady(memReady0), .memError(memError0), .busy(busy0)
  );

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        monE;
  logic [31:0] model[int];
  int          written[$];
  logic [31:0] lastData = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every memReady strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (memReady === 1'b1) begin
        if (sbQ.size() == 0) begin
          nChecks++;
          nFail++;
          $display("FAIL unexpected_ready: actual=1 required=0");
        end else begin
          monE = sbQ.pop_front();
          check("ready_cycle", cyc, monE.cyc);
          check("memData", memData, monE.data);
          check("memError", 32'(memError), 32'(monE.err));
          check("busy_in_access", 32'(busy), 32'd1);
        end
      end else if (memError !== 1'b0) begin
        check("error_without_ready", 32'(memError), 32'd0);
      end
    end
  end

  // Called at a negedge; waits for IDLE, presents the request for one edge and predicts the response.
  task automatic issue(input bit rd, input bit wr, input logic [15:0] addr, input logic [31:0] data);
    int   guard;
    int   idx;
    bit   err;
    exp_t e;
    guard = 0;
    while (busy !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("idle_timeout", 32'(guard), 32'd0);
    memRead = rd; memWrite = wr; memAddr = addr; writeMemData = data;
    @(posedge clk);
    #1;
    memRead = 1'b0; memWrite = 1'b0;
    err = (rd && wr) || (addr >= 16'h1000);
`ifdef MEM_ALIGN_CHECK_EN
    if (addr % 4 != 0) err = 1'b1;
`endif
    idx = int'(addr) / 4;
    if (!err && wr) begin
      model[idx] = data;
      written.push_back(idx);
    end
    if (!err && rd) lastData = model[idx];
    e.cyc  = cyc + WS;
    e.data = lastData;
    e.err  = err;
    sbQ.push_back(e);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sbQ.size() != 0 || busy !== 1'b0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("drain_timeout", 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    int          k, idx, lo, pulses, firstAt;
    logic [15:0] a;

    reset = 1'b0;
    memRead = 1'b0; memWrite = 1'b0; memAddr = 16'd0; writeMemData = 32'd0;
    r0 = 1'b0; w0 = 1'b0; a0 = 16'd0; d0 = 32'd0;

    repeat (2) @(negedge clk);
    check("reset_memData", memData, 32'd0);
    check("reset_memReady", 32'(memReady), 32'd0);
    check("reset_memError", 32'(memError), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 16'h0010, 32'd0);
    issue(1'b1, 1'b0, 16'h1000, 32'd0);
    issue(1'b0, 1'b1, 16'h0020, 32'hCAFEF00D);
    issue(1'b1, 1'b1, 16'h0020, 32'h11111111);
    issue(1'b1, 1'b0, 16'h0020, 32'd0);
    issue(1'b1, 1'b0, 16'h0012, 32'd0);
    issue(1'b0, 1'b1, 16'h0FFC, 32'hA5A55A5A);
    issue(1'b1, 1'b0, 16'h0FFC, 32'd0);
    issue(1'b0, 1'b1, 16'hFFFC, 32'h77777777);
    issue(1'b0, 1'b1, 16'h0030, 32'h0BADF00D);
    drain();

    // Reset in the middle of a write must abort it.
    @(negedge clk);
    memWrite = 1'b1; memAddr = 16'h0030; writeMemData = 32'h12345678;
    @(posedge clk);
    #1;
    memWrite = 1'b0;
    @(negedge clk);
    check("busy_in_wait", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_memData", memData, 32'd0);
    check("abort_memReady", 32'(memReady), 32'd0);
    check("abort_memError", 32'(memError), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    sbQ.delete();
    lastData = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, 16'h0030, 32'd0);

    for (int i = 0; i < 80; i++) begin
      k  = $urandom_range(0, 9);
      lo = $urandom_range(0, 3);
      if (k >= 4 && k <= 7 && written.size() == 0) k = 0;
      if (k <= 3) begin
        idx = $urandom_range(0, 1023);
        a   = 16'(idx * 4 + lo);
        issue(1'b0, 1'b1, a, $urandom);
      end else if (k <= 7) begin
        idx = written[$urandom_range(0, written.size() - 1)];
        a   = 16'(idx * 4 + lo);
        issue(1'b1, 1'b0, a, $urandom);
      end else if (k == 8) begin
        a = 16'($urandom_range(16'h1000, 16'hFFFF));
        if ($urandom_range(0, 1) == 1) issue(1'b1, 1'b0, a, $urandom);
        else                           issue(1'b0, 1'b1, a, $urandom);
      end else begin
        idx = $urandom_range(0, 1023);
        issue(1'b1, 1'b1, 16'(idx * 4), $urandom);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Zero wait states: a read held across three edges is accepted twice.
    @(negedge clk);
    w0 = 1'b1; a0 = 16'h0040; d0 = 32'h5A5A1234;
    @(posedge clk);
    #1;
    w0 = 1'b0;
    @(negedge clk);
    check("wait0_write_ready", 32'(memReady0), 32'd1);
    check("wait0_write_error", 32'(memError0), 32'd0);
    @(negedge clk);
    r0 = 1'b1; a0 = 16'h0040;
    pulses  = 0;
    firstAt = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (memReady0 === 1'b1) begin
        pulses++;
        if (firstAt == 0) firstAt = i;
        check("wait0_read_data", memData0, 32'h5A5A1234);
      end
      if (i == 3) r0 = 1'b0;
    end
    check("wait0_pulse_count", 32'(pulses), 32'd2);
    check("wait0_first_latency", 32'(firstAt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
